// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: state encoding and defaults
// shared by the fetch sequencing controller.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory req/ready
// handshake between fetch control and imem.
interface fetch_ctrl_if;
  logic req;
  logic ready;

  modport master (output req, input ready);
  modport slave  (input req, output ready);
endinterface

// File: rtl/fetch_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the
// load in EX and the sources of the ID instruction.
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hz
);
  assign hz = mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == rs) || (ex_rt == rt));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC/IF-ID sequencing with buffered
// redirects and saturating stall/flush counters.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_pc_src,
  input  logic [31:0]      ex_mem_npc,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  fetch_ctrl_if.master     imem,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [31:0]      redirect_pc,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t      state, nxt;
  logic        pend, pend_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        hz;
  logic        stall_inc, flush_inc;

  hazard_detect u_hz (
    .mem_read (id_ex_mem_read),
    .ex_rt    (id_ex_rt),
    .rs       (if_id_rs),
    .rt       (if_id_rt),
    .hz       (hz)
  );

  assign redirect_pc = ex_mem_pc_src ? ex_mem_npc
                                     : pend_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pend      <= 1'b0;
      pend_pc   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= nxt;
      pend    <= pend_nxt;
      pend_pc <= pend_pc_nxt;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt          = state;
    pend_nxt     = pend;
    pend_pc_nxt  = pend_pc;
    imem.req     = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state)
        BOOT: begin
          imem.req    = 1'b1;
          if_id_flush = 1'b1;
          nxt         = RUN;
        end
        RUN, WAIT: begin
          imem.req = 1'b1;
          // rules overlap, so the first match wins
          priority case (1'b1)
            ex_mem_pc_src: begin
              if_id_flush  = 1'b1;
              id_ex_flush  = 1'b1;
              ex_mem_flush = 1'b1;
              flush_inc    = 1'b1;
              if (imem.ready) begin
                pc_sel   = 1'b1;
                pc_write = 1'b1;
                pend_nxt = 1'b0;
                nxt      = RUN;
              end else begin
                pend_pc_nxt = ex_mem_npc;
                pend_nxt    = 1'b1;
                nxt         = WAIT;
              end
            end
            hz: begin
              id_ex_flush = 1'b1;
              stall_inc   = 1'b1;
              if (!imem.ready) nxt = WAIT;
            end
            !imem.ready: begin
              if_id_flush = 1'b1;
              stall_inc   = 1'b1;
              nxt         = WAIT;
            end
            pend: begin
              pc_sel      = 1'b1;
              pc_write    = 1'b1;
              if_id_flush = 1'b1;
              pend_nxt    = 1'b0;
              nxt         = RUN;
            end
            default: begin
              pc_write    = 1'b1;
              if_id_write = 1'b1;
              nxt         = RUN;
            end
          endcase
        end
        default: nxt = BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus
// against a spec-level reference model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] npc = '0;
  logic        mem_read = 1'b0;
  logic [4:0]  ex_rt = '0, rs = '0, rt = '0;
  logic        ready = 1'b0;

  logic        pc_write, pc_sel, if_id_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_pc_sel, s_if_id_write;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  fetch_ctrl_if imem0 ();
  fetch_ctrl_if imem1 ();
  assign imem0.ready = ready;
  assign imem1.ready = ready;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_mem_pc_src(pc_src), .ex_mem_npc(npc),
    .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt),
    .imem(imem0),
    .pc_write(pc_write), .pc_sel(pc_sel),
    .redirect_pc(redirect_pc),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .ex_mem_pc_src(pc_src), .ex_mem_npc(npc),
    .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt),
    .imem(imem1),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel),
    .redirect_pc(s_redirect_pc),
    .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // reference model: booting flag, pending target, raw event counts
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  logic [31:0] m_target = '0;
  int          m_st = 0, m_fl = 0;
  logic [6:0]  e_ctl;
  logic [31:0] e_rpc;

  function automatic bit hazard();
    return mem_read && ex_rt != 0 &&
           (ex_rt == rs || ex_rt == rt);
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ctl = {req,pc_write,pc_sel,if_id_write,if_id_flush,id_ex_flush,ex_mem_flush}
  task automatic model_eval();
    e_rpc = pc_src ? npc : m_target;
    if (rst)              e_ctl = 7'b0000111;
    else if (m_boot)      e_ctl = 7'b1000100;
    else if (pc_src)      e_ctl = ready ? 7'b1110111 : 7'b1000111;
    else if (hazard())    e_ctl = 7'b1000010;
    else if (!ready)      e_ctl = 7'b1000100;
    else if (m_pend)      e_ctl = 7'b1110100;
    else                  e_ctl = 7'b1101000;
  endtask

  task automatic model_tick();
    if (rst) begin
      m_boot = 1; m_pend = 0; m_target = '0; m_st = 0; m_fl = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (pc_src) begin
      m_fl++;
      if (ready) m_pend = 0;
      else begin m_pend = 1; m_target = npc; end
    end else if (hazard() || !ready) begin
      m_st++;
    end else if (m_pend) begin
      m_pend = 0;
    end
  endtask

  function automatic logic [85:0] obs();
    return {imem0.req, pc_write, pc_sel, if_id_write,
            if_id_flush, id_ex_flush, ex_mem_flush,
            redirect_pc, stall_cnt, flush_cnt,
            s_stall_cnt, s_flush_cnt,
            imem1.req, s_pc_write, s_pc_sel, s_if_id_write,
            s_if_id_flush, s_id_ex_flush, s_ex_mem_flush};
  endfunction

  function automatic logic [85:0] expv();
    logic [15:0] a = 16'(sat(m_st, 65535));
    logic [15:0] b = 16'(sat(m_fl, 65535));
    logic [3:0]  c = 4'(sat(m_st, 15));
    logic [3:0]  d = 4'(sat(m_fl, 15));
    return {e_ctl, e_rpc, a, b, c, d, e_ctl};
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic drive(bit s, logic [31:0] t, bit r);
    pc_src = s; npc = t; ready = r;
  endtask

  task automatic test_reset();
    rst = 1; drive(0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_vec: got %h want %h", obs(), expv());
      end
      n_chk++;
      if (imem0.req !== 1'b0 || pc_write !== 1'b0 ||
          {if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_ctl: req=%b pcw=%b fl=%b want 0 0 111",
                 imem0.req, pc_write,
                 {if_id_flush, id_ex_flush, ex_mem_flush});
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_boot_run();
    drive(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL boot_run_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      n_chk++;
      if (i == 0 && (pc_write !== 1'b0 || if_id_flush !== 1'b1)) begin
        n_fail++;
        $display("FAIL boot_cycle: pcw=%b iff=%b want 0 1", pc_write, if_id_flush);
      end else if (i > 0 && {pc_write, if_id_write, pc_sel} !== 3'b110) begin
        n_fail++;
        $display("FAIL run_cycle: pcw/ifw/sel=%b want 110",
                 {pc_write, if_id_write, pc_sel});
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1, 32'h40, 1);
    settle();
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL redirect_vec: got %h want %h", obs(), expv());
    end
    n_chk++;
    if (pc_sel !== 1'b1 || redirect_pc !== 32'h40 ||
        {if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin
      n_fail++;
      $display("FAIL redirect_ctl: sel=%b rpc=%h want 1 00000040", pc_sel, redirect_pc);
    end
    tick();
    drive(0, 0, 1);
    n_chk++;
    if (flush_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL redirect_cnt: flush_cnt=%0d want 1", flush_cnt);
    end
  endtask

  task automatic test_wait_redirect();
    logic [31:0] tg [4] = '{32'h0, 32'h80, 32'hC0, 32'h0};
    bit          sv [4] = '{0, 1, 1, 0};
    int st0 = m_st, fl0 = m_fl;
    for (int i = 0; i < 4; i++) begin
      drive(sv[i], tg[i], i == 3);
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL wait_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i == 3) begin
        n_chk++;
        if (pc_sel !== 1'b1 || redirect_pc !== 32'hC0 || if_id_flush !== 1'b1) begin
          n_fail++;
          $display("FAIL wait_apply: sel=%b rpc=%h iff=%b want 1 000000c0 1",
                   pc_sel, redirect_pc, if_id_flush);
        end
        n_chk++;
        if (stall_cnt !== 16'(st0 + 1) || flush_cnt !== 16'(fl0 + 2)) begin
          n_fail++;
          $display("FAIL wait_cnt: st=%0d fl=%0d want %0d %0d",
                   stall_cnt, flush_cnt, st0 + 1, fl0 + 2);
        end
      end
      tick();
    end
    drive(0, 0, 1);
  endtask

  task automatic test_hazard();
    logic [4:0] rts [2] = '{5'd5, 5'd0};
    for (int i = 0; i < 2; i++) begin
      mem_read = 1; ex_rt = rts[i]; rs = rts[i]; rt = 5'd9;
      drive(0, 0, 1);
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL hazard_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      n_chk++;
      if (pc_write !== (i == 1) || id_ex_flush !== (i == 0)) begin
        n_fail++;
        $display("FAIL hazard_ctl[%0d]: pcw=%b idf=%b want %b %b",
                 i, pc_write, id_ex_flush, i == 1, i == 0);
      end
      tick();
    end
    mem_read = 0; ex_rt = 0; rs = 0;
  endtask

  task automatic test_coincident();
    int st0;
    mem_read = 1; ex_rt = 5'd7; rt = 5'd7; rs = 5'd0;
    drive(1, 32'h1234, 1);
    st0 = m_st;
    settle();
    n_chk++;
    if (obs() !== expv() || pc_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_hz_vec: got %h want %h", obs(), expv());
    end
    tick();
    mem_read = 0;
    n_chk++;
    if (stall_cnt !== 16'(st0)) begin
      n_fail++;
      $display("FAIL redir_hz_cnt: st=%0d want %0d", stall_cnt, st0);
    end
    drive(1, 32'h100, 0); settle(); tick();
    drive(1, 32'h200, 1);
    settle();
    n_chk++;
    if (obs() !== expv() || redirect_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL live_npc: rpc=%h want 00000200", redirect_pc);
    end
    tick();
    drive(0, 0, 1);
  endtask

  task automatic test_saturation();
    rst = 1; drive(0, 0, 0); settle(); tick();
    rst = 0;
    for (int i = 0; i < 21; i++) begin
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL sat_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      tick();
    end
    n_chk++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_hold: s4=%h s16=%0d want f 20", s_stall_cnt, stall_cnt);
    end
    drive(0, 0, 1);
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 32'h300, 0); settle(); tick();
    drive(0, 0, 0); settle(); tick();
    rst = 1; settle(); tick();
    rst = 0; drive(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL rst_wait_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      n_chk++;
      if (pc_sel !== 1'b0 || pc_write !== (i != 0)) begin
        n_fail++;
        $display("FAIL rst_wait_ctl[%0d]: sel=%b pcw=%b want 0 %b",
                 i, pc_sel, pc_write, i != 0);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      pc_src   = ($urandom_range(0, 6) == 0);
      npc      = $urandom & 32'hFFFF_FFFC;
      ready    = ($urandom_range(0, 9) < 7);
      mem_read = ($urandom_range(0, 2) == 0);
      ex_rt    = 5'($urandom_range(0, 3));
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      settle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random_vec[%0d]: got %h want %h", i, obs(), expv());
      end
      tick();
    end
    rst = 0; mem_read = 0; drive(0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_boot_run();
    test_redirect();
    test_wait_redirect();
    test_hazard();
    test_coincident();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
